gpcfg_regbank_p: RTL and testbench

GPCFG_REGBANK_P -- requirements
Module: gpcfg_regbank_p

---
 rtl/gpcfg_regbank_p.sv | 136 +++++++++++++
 tb/tb_gpcfg_regbank_p.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpcfg_regbank_p.sv
// gpcfg_regbank_p: bank of NUM_REGS 32-bit configuration/status registers.
// Each register has a fixed access mode (RW, RO, W1C or PULSE) chosen by the MODE
// parameter. Writes take effect at the next edge. Reads return registered data one
// cycle after the request, together with a one-cycle valid strobe. A single error
// strobe flags any read or write to an address that does not map to a register.
module gpcfg_regbank_p #(
   parameter int                       NUM_REGS  = 4,
   parameter logic [15:0]              BASE_ADDR = 16'h0,
   parameter logic [NUM_REGS*32-1:0]   RESET_VAL = {NUM_REGS*32{1'b0}},
   parameter logic [NUM_REGS*2-1:0]    MODE      = {NUM_REGS*2{1'b0}}
) (
   input  logic                     hclk,
   input  logic                     hreset,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [3:0]               byte_en,
   input  logic [31:0]              wr_addr,
   input  logic [31:0]              rd_addr,
   input  logic [31:0]              wdata,
   input  logic [NUM_REGS*32-1:0]   hw_in,
   output logic [NUM_REGS*32-1:0]   cfg_out,
   output logic [31:0]              rdata,
   output logic                     rd_valid,
   output logic                     addr_err
);

   // Per-register access behaviour, encoded two bits per register in MODE.
   typedef enum logic [1:0] {
      MODE_RW    = 2'b00,
      MODE_RO    = 2'b01,
      MODE_W1C   = 2'b10,
      MODE_PULSE = 2'b11
   } regMode_e;

   logic [NUM_REGS-1:0] wrHit;
   logic [NUM_REGS-1:0] rdHit;
   logic [31:0]         byteMask;
   logic [31:0]         wrMasked;
   logic [31:0]         rdMux;
   logic                wrMiss;
   logic                rdMiss;

   // Only the low 16 address bits are decoded, and hw_in bits of RW/PULSE
   // registers have no effect; this collects them so they are visibly consumed.
   logic                unusedInputs;
   assign unusedInputs = ^{wr_addr[31:16], rd_addr[31:16], hw_in};

   // Expand the byte enables into a bit mask; wrMasked is the write data restricted
   // to the enabled bytes, which every writable mode consumes.
   assign byteMask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
   assign wrMasked = wdata & byteMask;

   // A request with no matching register is a miss; misaligned addresses never match
   // because register addresses are all multiples of four from an aligned base.
   assign wrMiss = wr_en && (wrHit == '0);
   assign rdMiss = rd_en && (rdHit == '0);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam logic [15:0] REG_ADDR = BASE_ADDR + 16'(4 * i);
      localparam regMode_e    REG_MODE = regMode_e'(MODE[2*i +: 2]);
      localparam logic [31:0] REG_INIT = ((REG_MODE == MODE_RW) || (REG_MODE == MODE_W1C))
                                         ? RESET_VAL[32*i +: 32] : 32'h0;

      logic [31:0] regQ;
      logic [31:0] regNext;
      logic [31:0] hwSlice;

      assign wrHit[i] = wr_en && (wr_addr[15:0] == REG_ADDR);
      assign rdHit[i] = rd_en && (rd_addr[15:0] == REG_ADDR);
      assign hwSlice  = hw_in[32*i +: 32];

      // Next-value logic for this register according to its fixed mode. W1C lets a
      // hardware set override a software clear of the same bit in the same cycle;
      // PULSE holds written bytes for one cycle and otherwise returns to zero.
      always_comb begin
         regNext = regQ;
         case (REG_MODE)
            MODE_RW: begin
               if (wrHit[i]) begin
                  regNext = (regQ & ~byteMask) | wrMasked;
               end
            end
            MODE_RO: begin
               regNext = hwSlice;
            end
            MODE_W1C: begin
               if (wrHit[i]) begin
                  regNext = (regQ & ~wrMasked) | hwSlice;
               end else begin
                  regNext = regQ | hwSlice;
               end
            end
            default: begin
               regNext = wrHit[i] ? wrMasked : 32'h0;
            end
         endcase
      end

      // Register storage; RW and W1C reset to their programmed value, RO and PULSE to zero.
      always_ff @(posedge hclk or posedge hreset) begin
         if (hreset) begin
            regQ <= REG_INIT;
         end else begin
            regQ <= regNext;
         end
      end

      assign cfg_out[32*i +: 32] = regQ;
   end

   // Read multiplexer: selects the addressed register's current (pre-edge) value,
   // or zero when the read misses or no read is requested.
   always_comb begin
      rdMux = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rdHit[i]) begin
            rdMux = cfg_out[32*i +: 32];
         end
      end
   end

   // Registered read response and error strobe. Reset discards any read in flight,
   // and a cycle with both a read miss and a write miss still gives one error pulse.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         rdata    <= 32'h0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         rdata    <= rdMux;
         rd_valid <= rd_en;
         addr_err <= wrMiss || rdMiss;
      end
   end

endmodule

// File: tb/tb_gpcfg_regbank_p.sv
// tb_gpcfg_regbank_p: directed testbench for gpcfg_regbank_p with a scoreboard.
// Register map under test: reg0 RW, reg1 RW (reset A5A5_0000), reg2 W1C, reg3 PULSE.
module tb_gpcfg_regbank_p;

   localparam int NUM_REGS = 4;

   logic                   hclk;
   logic                   hreset;
   logic                   wr_en;
   logic                   rd_en;
   logic [3:0]             byte_en;
   logic [31:0]            wr_addr;
   logic [31:0]            rd_addr;
   logic [31:0]            wdata;
   logic [NUM_REGS*32-1:0] hw_in;
   logic [NUM_REGS*32-1:0] cfg_out;
   logic [31:0]            rdata;
   logic                   rd_valid;
   logic                   addr_err;

   logic [NUM_REGS*32-1:0] hwDrive;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic        err;
   } expect_t;

   expect_t expQ[$];
   string   nameQ[$];

   int nCompared;
   int nMismatched;

   gpcfg_regbank_p #(
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (16'h0),
      .RESET_VAL ({32'h0, 32'h0, 32'hA5A5_0000, 32'h0}),
      .MODE      (8'b11_10_00_00)
   ) dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .byte_en  (byte_en),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .wdata    (wdata),
      .hw_in    (hw_in),
      .cfg_out  (cfg_out),
      .rdata    (rdata),
      .rd_valid (rd_valid),
      .addr_err (addr_err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   // Compare one observed value with its expected value and record the outcome.
   task automatic checkOutput(input string nm, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", nm, actual, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the response the DUT
   // must present after the following rising edge.
   task automatic applyStimulus(input string nm,
                                input logic w, input logic [31:0] wa, input logic [3:0] be,
                                input logic [31:0] wd,
                                input logic r, input logic [31:0] ra,
                                input logic [31:0] expData, input logic expErr);
      expect_t e;
      @(negedge hclk);
      wr_en   = w;
      wr_addr = wa;
      byte_en = be;
      wdata   = wd;
      rd_en   = r;
      rd_addr = ra;
      hw_in   = hwDrive;
      e.valid = r;
      e.data  = r ? expData : 32'h0;
      e.err   = expErr;
      expQ.push_back(e);
      nameQ.push_back(nm);
   endtask

   task automatic idle(input string nm);
      applyStimulus(nm, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   // Monitor: after every rising edge, pop the expected response for the cycle just
   // closed; with nothing queued the outputs must be idle.
   initial begin
      expect_t e;
      string   nm;
      forever begin
         @(posedge hclk);
         #1;
         if (expQ.size() > 0) begin
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            checkOutput({nm, " rd_valid"}, {31'h0, rd_valid}, {31'h0, e.valid});
            checkOutput({nm, " rdata"},    rdata,             e.data);
            checkOutput({nm, " addr_err"}, {31'h0, addr_err}, {31'h0, e.err});
         end else begin
            checkOutput("idle rd_valid", {31'h0, rd_valid}, 32'h0);
            checkOutput("idle addr_err", {31'h0, addr_err}, 32'h0);
         end
      end
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence.
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      hreset  = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      byte_en = 4'h0;
      wr_addr = 32'h0;
      rd_addr = 32'h0;
      wdata   = 32'h0;
      hwDrive = '0;
      hw_in   = '0;

      repeat (3) @(negedge hclk);
      checkOutput("reset reg0", cfg_out[31:0],   32'h0);
      checkOutput("reset reg1", cfg_out[63:32],  32'hA5A5_0000);
      checkOutput("reset reg2", cfg_out[95:64],  32'h0);
      checkOutput("reset reg3", cfg_out[127:96], 32'h0);
      checkOutput("reset rdata", rdata, 32'h0);
      checkOutput("reset rd_valid", {31'h0, rd_valid}, 32'h0);
      hreset = 1'b0;

      // Reset value readback and hold across idle cycles.
      applyStimulus("rd reg1 reset", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 32'hA5A5_0000, 1'b0);
      for (int k = 0; k < 5; k++) idle("hold idle");
      checkOutput("hold reg1", cfg_out[63:32], 32'hA5A5_0000);
      checkOutput("hold reg0", cfg_out[31:0],  32'h0);

      // RW partial-byte write with same-cycle read of the old value.
      applyStimulus("wr+rd reg0", 1'b1, 32'h0, 4'b0101, 32'h1234_5678, 1'b1, 32'h0, 32'h0, 1'b0);
      applyStimulus("rd reg0 new", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 32'h0034_0078, 1'b0);
      checkOutput("cfg reg0 bytes", cfg_out[31:0], 32'h0034_0078);

      // Write hit with no byte enables changes nothing and is not an error.
      applyStimulus("wr reg1 be0", 1'b1, 32'h4, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus("rd reg1 be0", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 32'hA5A5_0000, 1'b0);
      applyStimulus("wr reg1 full", 1'b1, 32'h4, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus("rd reg1 full", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0);

      // W1C: hardware set, set winning over clear, byte-enable gating, then a real clear.
      hwDrive[67] = 1'b1;
      idle("w1c hw set");
      hwDrive[67] = 1'b0;
      applyStimulus("rd w1c set", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 32'h8, 1'b0);
      hwDrive[67] = 1'b1;
      applyStimulus("w1c clr vs set", 1'b1, 32'h8, 4'b0001, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
      hwDrive[67] = 1'b0;
      applyStimulus("w1c clr no be", 1'b1, 32'h8, 4'b1110, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus("rd w1c kept", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 32'h8, 1'b0);
      applyStimulus("w1c clr", 1'b1, 32'h8, 4'b0001, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus("rd w1c clr", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 32'h0, 1'b0);

      // PULSE: single write is high one cycle; back-to-back writes stay high two.
      applyStimulus("pulse wr", 1'b1, 32'hC, 4'hF, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);
      idle("pulse idle1");
      checkOutput("pulse high", cfg_out[127:96], 32'h1);
      idle("pulse idle2");
      checkOutput("pulse cleared", cfg_out[127:96], 32'h0);
      applyStimulus("pulse wr a", 1'b1, 32'hC, 4'hF, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus("pulse wr b", 1'b1, 32'hC, 4'hF, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("pulse b2b 1", cfg_out[127:96], 32'h1);
      idle("pulse idle3");
      checkOutput("pulse b2b 2", cfg_out[127:96], 32'h1);
      idle("pulse idle4");
      checkOutput("pulse b2b off", cfg_out[127:96], 32'h0);

      // Unmapped accesses: combined miss gives one pulse; single misses each flag.
      applyStimulus("miss rd+wr", 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h2, 32'h0, 1'b1);
      idle("after miss");
      applyStimulus("miss wr misalign", 1'b1, 32'h5, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b1);
      applyStimulus("miss rd 0x10", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h10, 32'h0, 1'b1);
      applyStimulus("hi addr bits", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 1'b0);
      idle("miss settle");
      checkOutput("miss reg0", cfg_out[31:0],   32'h0034_0078);
      checkOutput("miss reg1", cfg_out[63:32],  32'hDEAD_BEEF);
      checkOutput("miss reg2", cfg_out[95:64],  32'h0);
      checkOutput("miss reg3", cfg_out[127:96], 32'h0);

      // Reset mid-sequence with a modified RW register and a read in flight.
      applyStimulus("wr reg0 ff", 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0);
      idle("pre reset");
      checkOutput("pre reset reg0", cfg_out[31:0], 32'hFFFF_FFFF);
      applyStimulus("rd killed by reset", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h4, 32'h0, 1'b0);
      rd_en = 1'b1;
      #2;
      hreset = 1'b1;
      @(negedge hclk);
      rd_en = 1'b0;
      checkOutput("mid reset rd_valid", {31'h0, rd_valid}, 32'h0);
      checkOutput("mid reset reg0", cfg_out[31:0],   32'h0);
      checkOutput("mid reset reg1", cfg_out[63:32],  32'hA5A5_0000);
      checkOutput("mid reset reg2", cfg_out[95:64],  32'h0);
      checkOutput("mid reset reg3", cfg_out[127:96], 32'h0);
      @(negedge hclk);
      hreset = 1'b0;
      applyStimulus("post reset wr", 1'b1, 32'h0, 4'hF, 32'h0000_00AA, 1'b1, 32'h4, 32'hA5A5_0000, 1'b0);
      applyStimulus("post reset rd", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 32'h0000_00AA, 1'b0);
      idle("final idle");

      // Let the monitor drain the scoreboard, bounded in cycles.
      for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge hclk);
      #2;
      if (expQ.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
